stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch (0.1 s resolution) with run/pause/clear control,
// saturation at 999.9 and a multiplexed digit-scan output.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        full,
  output logic [3:0]  seg_sel,
  output logic [3:0]  seg_bcd
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t        state_r, state_next_s;
  logic [PW-1:0] presc_r, presc_next_s;
  logic [15:0]   digits_r, digits_next_s;
  logic [SW-1:0] scan_r, scan_next_s;
  logic [1:0]    idx_r, idx_next_s;
  logic [3:0]    seg_sel_r, seg_sel_next_s;
  logic [3:0]    seg_bcd_r, seg_bcd_next_s;
  logic          tick_s;
  logic          at_max_s;

  // Ripple-carry BCD increment; any nibble at 9 or above rolls to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    logic        c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (d[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = d[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign tick_s   = (state_r == RUN) && (presc_r == PRESC_MAX);
  assign at_max_s = (digits_r == 16'h9999);

  // Next-state logic; clear has priority over start_stop everywhere.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_stop && !clear) state_next_s = RUN;
        else                      state_next_s = IDLE;
      end
      RUN: begin
        if (clear)                     state_next_s = IDLE;
        else if (start_stop)           state_next_s = PAUSE;
        else if (tick_s && at_max_s)   state_next_s = FULL;
        else                           state_next_s = RUN;
      end
      PAUSE: begin
        if (clear)           state_next_s = IDLE;
        else if (start_stop) state_next_s = RUN;
        else                 state_next_s = PAUSE;
      end
      FULL: begin
        if (clear) state_next_s = IDLE;
        else       state_next_s = FULL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Prescaler and digit datapath; IDLE keeps the prescaler at zero for the next start.
  always_comb begin
    presc_next_s  = presc_r;
    digits_next_s = digits_r;
    if (clear) begin
      presc_next_s = '0;
    end else if (state_r == IDLE) begin
      presc_next_s = '0;
    end else if (state_r == RUN) begin
      if (tick_s) presc_next_s = '0;
      else        presc_next_s = presc_r + PW'(1);
    end else begin
      presc_next_s = presc_r;
    end
    if (clear) begin
      digits_next_s = 16'h0000;
    end else if (tick_s && !at_max_s) begin
      digits_next_s = bcd_inc(digits_r);
    end else begin
      digits_next_s = digits_r;
    end
  end

  // Free-running display scan; select and value are both derived from the new index.
  always_comb begin
    scan_next_s = scan_r;
    idx_next_s  = idx_r;
    if (scan_r == SCAN_MAX) begin
      scan_next_s = '0;
      idx_next_s  = idx_r + 2'd1;
    end else begin
      scan_next_s = scan_r + SW'(1);
      idx_next_s  = idx_r;
    end
    seg_sel_next_s = ~(4'b0001 << idx_next_s);
    case (idx_next_s)
      2'd0:    seg_bcd_next_s = digits_r[3:0];
      2'd1:    seg_bcd_next_s = digits_r[7:4];
      2'd2:    seg_bcd_next_s = digits_r[11:8];
      2'd3:    seg_bcd_next_s = digits_r[15:12];
      default: seg_bcd_next_s = 4'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      presc_r   <= '0;
      digits_r  <= 16'h0000;
      scan_r    <= '0;
      idx_r     <= 2'd0;
      seg_sel_r <= 4'b1110;
      seg_bcd_r <= 4'd0;
    end else begin
      state_r   <= state_next_s;
      presc_r   <= presc_next_s;
      digits_r  <= digits_next_s;
      scan_r    <= scan_next_s;
      idx_r     <= idx_next_s;
      seg_sel_r <= seg_sel_next_s;
      seg_bcd_r <= seg_bcd_next_s;
    end
  end

  assign digits  = digits_r;
  assign running = (state_r == RUN);
  assign full    = (state_r == FULL);
  assign seg_sel = seg_sel_r;
  assign seg_bcd = seg_bcd_r;

endmodule
